usb_rx_deserializer: RTL and testbench



---
 rtl/usb_rx_deserializer_pkg.sv | 21 ++
 rtl/usb_rx_deserializer_nrzi_unstuff.sv | 80 ++++++++
 rtl/usb_rx_deserializer.sv | 148 ++++++++++++++
 tb/tb_usb_rx_deserializer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_deserializer_pkg.sv
// Shared types and constants for the USB receive deserializer.
// Holds the FSM encoding, stuffing/byte constants and the NRZI decode helper.
package usb_rx_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2
    } rx_state_t;

    localparam int STUFF_LIMIT = 6;
    localparam int BYTE_BITS   = 8;

    localparam logic [2:0] OC_STUFF = 3'(STUFF_LIMIT);

    // NRZI: an unchanged line level encodes a 1.
    function automatic logic nrzi_decode(input logic d_cur, input logic d_last);
        return (d_cur == d_last);
    endfunction

endpackage

// File: rtl/usb_rx_deserializer_nrzi_unstuff.sv
// NRZI decoder plus consecutive-ones tracking for bit unstuffing.
// Classifies each qualified bit as data, dropped stuff bit or stuff violation.
module usb_nrzi_unstuff
    import usb_rx_deserializer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic en,
    input  logic se0,
    input  logic eop,
    input  logic usb_full_speed,
    input  logic idle,
    input  logic active,
    input  logic oc_load,
    output logic bit_out,
    output logic bit_vld,
    output logic stuff_drop,
    output logic stuff_err
);

    logic       d_prev_q, d_prev_d;
    logic [2:0] oc_q, oc_d;
    logic       qual_s;
    logic       b_s;
    logic       stuff_pos_s;

    assign qual_s      = en & ~se0 & ~eop;
    assign b_s         = nrzi_decode(d, d_prev_q);
    assign stuff_pos_s = active && (oc_q == OC_STUFF);

    assign bit_out    = b_s;
    assign bit_vld    = qual_s & ~stuff_pos_s;
    assign stuff_drop = qual_s & stuff_pos_s & ~b_s;
    assign stuff_err  = qual_s & stuff_pos_s & b_s;

    // Previous line level; parked at J while idle so SYNC decodes from a known level.
    always_comb begin
        d_prev_d = d_prev_q;
        if (qual_s) begin
            d_prev_d = d;
        end else if (idle) begin
            d_prev_d = usb_full_speed;
        end else begin
            d_prev_d = d_prev_q;
        end
    end

    // Ones counter; SYNC's final 1 seeds it at 1.
    always_comb begin
        oc_d = oc_q;
        if (oc_load) begin
            oc_d = 3'd1;
        end else if (!active) begin
            oc_d = 3'd0;
        end else if (qual_s) begin
            if (stuff_pos_s) begin
                oc_d = 3'd0;
            end else if (b_s) begin
                oc_d = oc_q + 3'd1;
            end else begin
                oc_d = 3'd0;
            end
        end else begin
            oc_d = oc_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_prev_q <= usb_full_speed;
            oc_q     <= 3'd0;
        end else begin
            d_prev_q <= d_prev_d;
            oc_q     <= oc_d;
        end
    end

endmodule

// File: rtl/usb_rx_deserializer.sv
// USB receive deserializer: SYNC detection, byte assembly and UTMI-style outputs.
// NRZI decode and unstuffing live in usb_nrzi_unstuff.
module usb_rx_deserializer
    import usb_rx_deserializer_pkg::*;
#(
    parameter int SYNC_ZEROS   = 3,
    parameter int DRIBBLE_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic       en,
    input  logic       se0,
    input  logic       eop,
    input  logic       usb_full_speed,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error
);

    localparam int              ZC_W    = $clog2(SYNC_ZEROS + 1);
    localparam logic [ZC_W-1:0] ZC_SAT  = ZC_W'(SYNC_ZEROS);
    localparam logic [ZC_W-1:0] ZC_ONE  = ZC_W'(1);
    localparam logic [2:0]      DRIB_LIM = 3'(DRIBBLE_BITS);

    rx_state_t            state_q, state_d;
    logic [ZC_W-1:0]      zc_q, zc_d;
    logic [2:0]           bc_q, bc_d;
    logic [BYTE_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_error_q, rx_error_d;
    logic                 rx_active_q, rx_active_d;

    logic bit_s, bit_vld_s, stuff_drop_s, stuff_err_s, oc_load_s;

    usb_nrzi_unstuff u_nrzi_unstuff (
        .clk            (clk),
        .reset          (reset),
        .d              (d),
        .en             (en),
        .se0            (se0),
        .eop            (eop),
        .usb_full_speed (usb_full_speed),
        .idle           (state_q == IDLE),
        .active         (state_q == ACTIVE),
        .oc_load        (oc_load_s),
        .bit_out        (bit_s),
        .bit_vld        (bit_vld_s),
        .stuff_drop     (stuff_drop_s),
        .stuff_err      (stuff_err_s)
    );

    // Next-state, byte assembly and output strobes.
    always_comb begin
        state_d    = state_q;
        zc_d       = zc_q;
        bc_d       = bc_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;
        oc_load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (eop) begin
                    zc_d = '0;
                end else if (bit_vld_s) begin
                    if (!bit_s) begin
                        zc_d = (zc_q == ZC_SAT) ? zc_q : zc_q + ZC_ONE;
                    end else if (zc_q >= ZC_SAT) begin
                        state_d   = ACTIVE;
                        oc_load_s = 1'b1;
                        bc_d      = 3'd0;
                        zc_d      = '0;
                    end else begin
                        zc_d = '0;
                    end
                end else begin
                    zc_d = zc_q;
                end
            end
            ACTIVE: begin
                if (eop) begin
                    state_d    = IDLE;
                    rx_error_d = !((bc_q == 3'd0) || (bc_q <= DRIB_LIM));
                end else if (stuff_err_s) begin
                    state_d    = ABORT;
                    rx_error_d = 1'b1;
                end else if (stuff_drop_s) begin
                    shreg_d = shreg_q;
                end else if (bit_vld_s) begin
                    shreg_d = {bit_s, shreg_q[BYTE_BITS-1:1]};
                    bc_d    = bc_q + 3'd1;
                    if (bc_q == 3'd7) begin
                        rx_data_d  = shreg_d;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else begin
                    shreg_d = shreg_q;
                end
            end
            ABORT: begin
                if (eop) begin
                    state_d = IDLE;
                end else begin
                    state_d = ABORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rx_active_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            zc_q        <= '0;
            bc_q        <= 3'd0;
            shreg_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
            rx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zc_q        <= zc_d;
            bc_q        <= bc_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_error_q  <= rx_error_d;
            rx_active_q <= rx_active_d;
        end
    end

    assign rx_active = rx_active_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Self-checking bench: builds packets at the bit level (SYNC, stuffing, NRZI line
// levels, EOP) and checks every output on every clock against expected values.
module tb_usb_rx_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       d, en, se0, eop, usb_full_speed;
    logic       rx_active, rx_valid, rx_error;
    logic [7:0] rx_data;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       line;
    logic       exp_active;
    logic [7:0] exp_data;
    logic [7:0] pkt[$];

    localparam int DRIBBLE = 1;

    usb_rx_deserializer dut (
        .clk            (clk),
        .reset          (reset),
        .d              (d),
        .en             (en),
        .se0            (se0),
        .eop            (eop),
        .usb_full_speed (usb_full_speed),
        .rx_active      (rx_active),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_error       (rx_error)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic xv, input logic xe);
        @(posedge clk);
        #1;
        chk("rx_valid", {7'd0, rx_valid}, {7'd0, xv});
        chk("rx_data", rx_data, exp_data);
        chk("rx_error", {7'd0, rx_error}, {7'd0, xe});
        chk("rx_active", {7'd0, rx_active}, {7'd0, exp_active});
    endtask

    task automatic idle_tick();
        en = 1'b0; se0 = 1'b0; eop = 1'b0; d = line;
        tick(1'b0, 1'b0);
    endtask

    // One recovered bit; random en gaps only once a packet is active.
    task automatic send_bit(input logic b, input logic xv, input logic [7:0] xd,
                            input logic xe, input logic act);
        if (exp_active) begin
            repeat ($urandom_range(0, 2)) idle_tick();
        end
        if (!b) line = ~line;
        d = line; en = 1'b1; se0 = 1'b0; eop = 1'b0;
        exp_active = act;
        if (xv) exp_data = xd;
        tick(xv, xe);
        en = 1'b0;
    endtask

    task automatic send_eop(input logic xe);
        se0 = 1'b1; en = 1'b1; d = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        eop = 1'b1;
        exp_active = 1'b0;
        tick(1'b0, xe);
        se0 = 1'b0; eop = 1'b0; en = 1'b0;
        line = usb_full_speed;
        d = line;
        tick(1'b0, 1'b0);
    endtask

    task automatic send_sync(input int nz, input logic detect);
        send_bit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < nz; i++) send_bit(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 8'h00, 1'b0, detect);
    endtask

    // Sends pkt[] LSB first with a stuffed 0 after every six consecutive 1s,
    // then 'extra' random dribble bits and an EOP.
    task automatic send_packet(input int nz, input int extra);
        int   ones;
        logic b;
        send_sync(nz, 1'b1);
        ones = 1;
        for (int k = 0; k < pkt.size(); k++) begin
            for (int i = 0; i < 8; i++) begin
                b = pkt[k][i];
                send_bit(b, (i == 7), pkt[k], 1'b0, 1'b1);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    send_bit(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
                    ones = 0;
                end
            end
        end
        for (int e = 0; e < extra; e++) begin
            b = 1'($urandom_range(0, 1));
            send_bit(b, 1'b0, 8'h00, 1'b0, 1'b1);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                send_bit(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
                ones = 0;
            end
        end
        send_eop(extra > DRIBBLE);
    endtask

    task automatic set_speed(input logic fs);
        usb_full_speed = fs;
        line = fs;
        idle_tick();
    endtask

    initial begin
        reset = 1'b1; usb_full_speed = 1'b1; d = 1'b1; en = 1'b0; se0 = 1'b0; eop = 1'b0;
        line = 1'b1; exp_active = 1'b0; exp_data = 8'h00;
        #12;
        chk("reset_valid", {7'd0, rx_valid}, 8'h00);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_error", {7'd0, rx_error}, 8'h00);
        chk("reset_active", {7'd0, rx_active}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        idle_tick();

        // Full-speed 0xC3 with a full SYNC
        pkt = '{8'hC3};
        send_packet(7, 0);

        // Stuffing across 0xFF, 0x01
        pkt = '{8'hFF, 8'h01};
        send_packet(7, 0);

        // Stuff error: six data 1s after SYNC's 1 make seven in a row
        send_sync(7, 1'b1);
        for (int k = 1; k <= 6; k++) send_bit(1'b1, 1'b0, 8'h00, (k == 6), 1'b1);
        for (int k = 0; k < 5; k++) send_bit(1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, 1'b1);
        send_eop(1'b0);

        // Alignment: 12 bits errors, 9 bits accepted as dribble
        pkt = '{8'h5A};
        send_packet(7, 4);
        pkt = '{8'hA5};
        send_packet(7, 1);

        // Low speed: inverted idle, same byte, minimal SYNC
        set_speed(1'b0);
        pkt = '{8'hC3};
        send_packet(7, 0);
        pkt = '{8'h3C};
        send_packet(3, 0);
        send_sync(2, 1'b0);
        send_bit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        send_eop(1'b0);

        // EOP in IDLE clears the zero count
        set_speed(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        se0 = 1'b1; eop = 1'b1; en = 1'b1;
        tick(1'b0, 1'b0);
        se0 = 1'b0; eop = 1'b0; en = 1'b0; line = usb_full_speed;
        idle_tick();
        send_bit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-byte, then a clean packet
        send_sync(7, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", {7'd0, rx_valid}, 8'h00);
        chk("rst_mid_data", rx_data, 8'h00);
        chk("rst_mid_error", {7'd0, rx_error}, 8'h00);
        chk("rst_mid_active", {7'd0, rx_active}, 8'h00);
        exp_active = 1'b0; exp_data = 8'h00;
        en = 1'b0; line = usb_full_speed; d = line;
        @(negedge clk);
        reset = 1'b0;
        idle_tick();
        pkt = '{8'h96};
        send_packet(7, 0);

        // Randomized packets
        for (int r = 0; r < 8; r++) begin
            set_speed(1'($urandom_range(0, 1)));
            pkt.delete();
            repeat ($urandom_range(1, 3)) pkt.push_back(8'($urandom_range(0, 255)));
            send_packet($urandom_range(3, 7), $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
